// File: rtl/w4a8_gemm_pkg.sv
// Shared types and helpers for the GEMM AXI4-Stream operand generator.
// Holds the FSM encoding, lane-count derivation and the all-ones keep/strb constant.
package w4a8_gemm_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StDone = 2'd2
   } gen_state_e;

   // Wide enough for tkeep/tstrb of streams up to 1024 bits; sliced by users.
   localparam int unsigned MaxKeepWidth = 128;
   localparam logic [MaxKeepWidth-1:0] KeepAllOnes = '1;

   function automatic int unsigned calc_lanes(input int unsigned data_w,
                                              input int unsigned lane_w);
      return data_w / lane_w;
   endfunction

endpackage

// File: rtl/w4a8_gemm_lane_pattern.sv
// Combinational incrementing-lane generator: lane i = base + i (wrapping).
// The parent registers the result, so this block adds no state.
module w4a8_gemm_lane_pattern #(
   parameter int unsigned Lanes     = 16,
   parameter int unsigned LaneWidth = 32
) (
   input  logic [LaneWidth-1:0]       base_i,
   output logic [Lanes*LaneWidth-1:0] data_o
);

   for (genvar i = 0; i < Lanes; i++) begin : g_lane
      assign data_o[i*LaneWidth +: LaneWidth] = base_i + LaneWidth'(i);
   end

endmodule

// File: rtl/w4a8_gemm_axis_stream_gen.sv
// AXI4-Stream master that emits a programmed number of incrementing-pattern beats,
// split into packets by tlast, and pulses ctrl_done when the transfer completes.
module w4a8_gemm_axis_stream_gen
   import w4a8_gemm_pkg::*;
#(
   parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
   parameter int unsigned C_ADDER_BIT_WIDTH  = 32,
   parameter int unsigned C_LENGTH_WIDTH     = 32,
   parameter int unsigned C_AXIS_TID_WIDTH   = 1,
   parameter int unsigned C_AXIS_TDEST_WIDTH = 1,
   parameter int unsigned C_AXIS_TUSER_WIDTH = 1
) (
   input  logic                            m_axis_aclk,
   input  logic                            m_axis_aresetn,
   input  logic                            ctrl_start,
   input  logic [C_LENGTH_WIDTH-1:0]       ctrl_length,
   input  logic [C_LENGTH_WIDTH-1:0]       ctrl_pkt_beats,
   input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_seed,
   output logic                            ctrl_busy,
   output logic                            ctrl_done,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                            m_axis_tlast,
   output logic [C_AXIS_TID_WIDTH-1:0]     m_axis_tid,
   output logic [C_AXIS_TDEST_WIDTH-1:0]   m_axis_tdest,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser
);

   localparam int unsigned Lanes = calc_lanes(C_AXIS_TDATA_WIDTH, C_ADDER_BIT_WIDTH);
   localparam int unsigned KeepW = C_AXIS_TDATA_WIDTH / 8;
   localparam int unsigned LW    = C_LENGTH_WIDTH;
   localparam int unsigned AW    = C_ADDER_BIT_WIDTH;

   gen_state_e                    state_q;
   logic [LW-1:0]                 len_q, pkt_q, beat_q, pkt_idx_q;
   logic [AW-1:0]                 base_q;
   logic [C_AXIS_TDATA_WIDTH-1:0] tdata_q;
   logic                          tvalid_q, tlast_q, busy_q, done_q;

   logic [AW-1:0]                 pat_base;
   logic [C_AXIS_TDATA_WIDTH-1:0] pat_data;
   logic                          handshake, final_beat, start_last, nxt_last;
   logic [LW-1:0]                 nxt_beat, nxt_pkt_idx;

   // In IDLE the pattern is built from the incoming seed so beat 0 is ready one cycle later.
   assign pat_base    = (state_q == StIdle) ? ctrl_seed : base_q;
   assign handshake   = tvalid_q & m_axis_tready;
   assign final_beat  = (beat_q == len_q - LW'(1));
   assign nxt_beat    = beat_q + LW'(1);
   assign nxt_pkt_idx = (pkt_idx_q == pkt_q - LW'(1)) ? '0 : pkt_idx_q + LW'(1);
   assign nxt_last    = (nxt_beat == len_q - LW'(1)) ||
                        ((pkt_q != '0) && (nxt_pkt_idx == pkt_q - LW'(1)));
   assign start_last  = (ctrl_length == LW'(1)) || (ctrl_pkt_beats == LW'(1));

   w4a8_gemm_lane_pattern #(
      .Lanes     (Lanes),
      .LaneWidth (AW)
   ) u_lane_pattern (
      .base_i (pat_base),
      .data_o (pat_data)
   );

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state_q   <= StIdle;
         len_q     <= '0;
         pkt_q     <= '0;
         beat_q    <= '0;
         pkt_idx_q <= '0;
         base_q    <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (ctrl_start) begin
                  len_q     <= ctrl_length;
                  pkt_q     <= ctrl_pkt_beats;
                  beat_q    <= '0;
                  pkt_idx_q <= '0;
                  busy_q    <= 1'b1;
                  if (ctrl_length == '0) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     tdata_q  <= pat_data;
                     base_q   <= ctrl_seed + AW'(Lanes);
                     tvalid_q <= 1'b1;
                     tlast_q  <= start_last;
                     state_q  <= StSend;
                  end
               end
            end
            StSend: begin
               if (handshake) begin
                  if (final_beat) begin
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     tdata_q   <= pat_data;
                     base_q    <= base_q + AW'(Lanes);
                     beat_q    <= nxt_beat;
                     pkt_idx_q <= nxt_pkt_idx;
                     tlast_q   <= nxt_last;
                  end
               end
            end
            StDone: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign ctrl_busy     = busy_q;
   assign ctrl_done     = done_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tkeep  = KeepAllOnes[KeepW-1:0];
   assign m_axis_tstrb  = KeepAllOnes[KeepW-1:0];
   assign m_axis_tid    = '0;
   assign m_axis_tdest  = '0;
   assign m_axis_tuser  = '0;

endmodule

// File: doc/w4a8_gemm_axis_stream_gen.md
Name: w4a8_gemm_axis_stream_gen

Overview:
- AXI4-Stream transmitter (master) that sources test/operand beats into the GEMM datapath's slave stream ports, e.g. the pipelined adder input.
- On a start pulse, it emits a programmed number of beats. Each beat is a vector of 32-bit lanes carrying a deterministic incrementing pattern, grouped into packets by tlast.
- Full-rate under no backpressure; AXI4-Stream compliant under backpressure.
- Reports completion with a done pulse.

Parameters:
- C_AXIS_TDATA_WIDTH, 512, stream data width; must be a multiple of C_ADDER_BIT_WIDTH.
- C_ADDER_BIT_WIDTH, 32, lane width.
- C_LENGTH_WIDTH, 32, width of beat and packet counters.
- C_AXIS_TID_WIDTH, 1, tid width.
- C_AXIS_TDEST_WIDTH, 1, tdest width.
- C_AXIS_TUSER_WIDTH, 1, tuser width.

Ports:
- m_axis_aclk  in  1  single clock for all logic.
- m_axis_aresetn  in  1  asynchronous active-low reset.
- ctrl_start  in  1  start request; sampled only in IDLE.
- ctrl_length  in  C_LENGTH_WIDTH  total beats to send.
- ctrl_pkt_beats  in  C_LENGTH_WIDTH  beats per packet; 0 means a single packet.
- ctrl_seed  in  C_ADDER_BIT_WIDTH  value of lane 0, beat 0.
- ctrl_busy  out  1  high when state is not IDLE.
- ctrl_done  out  1  one-cycle completion pulse.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  beat data.
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  all ones.
- m_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  all ones.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tid  out  C_AXIS_TID_WIDTH  zero.
- m_axis_tdest  out  C_AXIS_TDEST_WIDTH  zero.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  zero.

Behaviour:
- Clocking/reset: one clock (m_axis_aclk); reset is asynchronous and active-low (m_axis_aresetn).
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, done=0, state=IDLE, all counters 0. Reset asserted mid-transfer drops tvalid immediately and abandons the transfer; no done pulse is issued.
- LANES = C_AXIS_TDATA_WIDTH/C_ADDER_BIT_WIDTH.
- Lane data: lane i of beat n = ctrl_seed + n*LANES + i, modulo 2^C_ADDER_BIT_WIDTH (wraps silently).
  - Implement with a base register advanced by LANES per accepted beat; no per-beat multiplier.
- All outputs are registered.
- Config capture: ctrl_length, ctrl_pkt_beats and ctrl_seed are captured when start is accepted. Changes during a transfer have no effect.
- FSM states:
  - IDLE: if ctrl_start=1 and ctrl_length=0, go to DONE. Else if ctrl_start=1, load beat 0 onto the outputs, set tvalid=1, go to SEND; beat 0 is visible the cycle after start.
  - SEND: on a handshake (tvalid&tready), the next beat appears the following cycle, sustaining 1 beat/clk. On the handshake of the final beat, tvalid=0 and go to DONE.
  - DONE: ctrl_done=1 for exactly one cycle, then return to IDLE. ctrl_start is ignored in SEND and DONE.
- AXIS rules:
  - While tvalid=1 and tready=0, tdata, tlast and tvalid hold stable.
  - tvalid never depends combinationally on tready.
  - Hold transfers no beat.
- tlast: asserted on beat n when (n+1) mod pkt_beats == 0, or when n is the final beat. With pkt_beats=0, tlast is asserted on the final beat only. A final packet shorter than pkt_beats still ends with tlast.
- ctrl_busy = (state != IDLE).
- Latency: start at cycle t → first beat valid at t+1. Last handshake at cycle u → done at u+1, IDLE at u+2.
- A start pulse arriving in the same cycle as the done pulse is ignored.

Decomposition:
- Shared package w4a8_gemm_pkg holds:
  - FSM state encoding (IDLE/SEND/DONE).
  - LANES derivation function.
  - all-ones keep/strb constant.
- One natural sub-module: w4a8_gemm_lane_pattern. It takes the base register and produces the LANES-wide incrementing vector, as a combinational replicated adder that is registered by the parent.

Test Plan:
- Basic: seed=0, length=4, pkt_beats=0, tready=1 → 4 consecutive beats. Beat 1 lane 0 = 16 and lane 15 = 31. tlast only on beat 3. done one cycle after beat 3.
- Backpressure: length=8, tready toggling with a 50% random pattern → tdata/tlast held while stalled. Exactly 8 handshakes. Data sequence identical to the tready=1 run.
- Packetization: length=10, pkt_beats=4 → tlast on beats 3, 7 and 9. No other tlast.
- Zero length: length=0 with a start pulse → no tvalid ever. done pulses at t+1. busy high for exactly that one cycle.
- Wrap: seed=0xFFFFFFF8, length=1 → lanes 0..7 = 0xFFFFFFF8..0xFFFFFFFF, lane 8 = 0x00000000.
- Reset mid-op: length=100, assert aresetn=0 after 5 handshakes → tvalid=0 asynchronously and no done. A new start after release restarts at beat 0 of the new seed.
